// File: rtl/dma_pipe_ctrl_pkg.sv
// Shared types and constants for the DMA pipeline controller.
package dma_pipe_pkg;

    localparam int LANE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dma_pipe_ctrl_if.sv
// DMA peripheral-side bundle; master is the controller, slave the DMA engine.
interface dma_pipe_ctrl_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 42
);
    logic                  dma_rd_go;
    logic                  dma_rd_en;
    logic                  dma_wr_go;
    logic                  dma_wr_en;
    logic [ADDR_WIDTH-1:0] dma_rd_addr;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [ADDR_WIDTH:0]   dma_rd_size;
    logic [ADDR_WIDTH:0]   dma_wr_size;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic [DATA_WIDTH-1:0] dma_rd_data;
    logic                  dma_empty;
    logic                  dma_full;
    logic                  dma_rd_done;
    logic                  dma_wr_done;

    modport master (
        output dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en,
        output dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size, dma_wr_data,
        input  dma_rd_data, dma_empty, dma_full, dma_rd_done, dma_wr_done
    );

    modport slave (
        input  dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en,
        input  dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size, dma_wr_data,
        output dma_rd_data, dma_empty, dma_full, dma_rd_done, dma_wr_done
    );
endinterface

// File: rtl/dma_pipe_ctrl_lane_adder.sv
// Adds a 32-bit constant to every lane of a line; lanes wrap independently.
module lane_adder
    import dma_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LANE_WIDTH-1:0] addend,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign dout[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH] + addend;
    end
endmodule

// File: rtl/dma_pipe_ctrl.sv
// DMA copy controller: reads lines, adds a per-lane constant through a
// two-stage pipeline with backpressure, and writes them out.
module dma_pipe_ctrl
    import dma_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 42
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH:0]   size,
    input  logic [31:0]           addend,
    output logic                  done,
    dma_pipe_ctrl_if.master       dma
);
    state_t                state_r, state_next_s;
    logic                  go_accept_s;
    logic                  advance_s;
    logic                  rd_en_s;
    logic                  done_r, rd_go_r, wr_go_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r, wr_addr_r;
    logic [ADDR_WIDTH:0]   size_r, rd_count_r;
    logic                  v1_r, v2_r;
    logic [DATA_WIDTH-1:0] s1_r, s2_r, sum_s;

    lane_adder #(.DATA_WIDTH(DATA_WIDTH)) u_lane_adder (
        .din    (s1_r),
        .addend (addend),
        .dout   (sum_s)
    );

    // Next-state and go acceptance
    always_comb begin
        state_next_s = state_r;
        go_accept_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (go) begin
                    go_accept_s  = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if ((size_r == '0) || dma.dma_wr_done) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Pipeline flow control; a full sink only stalls when stage 2 holds a line
    always_comb begin
        advance_s = !(v2_r && dma.dma_full);
        rd_en_s   = (state_r == RUN) && !dma.dma_empty && advance_s && (rd_count_r < size_r);
    end

    // Control registers: state, request pulses, latched transfer parameters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            done_r     <= 1'b0;
            rd_go_r    <= 1'b0;
            wr_go_r    <= 1'b0;
            rd_addr_r  <= '0;
            wr_addr_r  <= '0;
            size_r     <= '0;
            rd_count_r <= '0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            rd_go_r <= go_accept_s;
            wr_go_r <= go_accept_s;
            if (go_accept_s) begin
                rd_addr_r  <= rd_addr;
                wr_addr_r  <= wr_addr;
                size_r     <= size;
                rd_count_r <= '0;
            end else if (rd_en_s) begin
                rd_count_r <= rd_count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
        end
    end

    // Two-stage datapath; everything holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            s1_r <= '0;
            s2_r <= '0;
        end else if (go_accept_s) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
        end else if (advance_s) begin
            v1_r <= rd_en_s;
            v2_r <= v1_r;
            if (rd_en_s) begin
                s1_r <= dma.dma_rd_data;
            end
            s2_r <= sum_s;
        end
    end

    assign done            = done_r;
    assign dma.dma_rd_go   = rd_go_r;
    assign dma.dma_wr_go   = wr_go_r;
    assign dma.dma_rd_en   = rd_en_s;
    assign dma.dma_wr_en   = v2_r && !dma.dma_full;
    assign dma.dma_rd_addr = rd_addr_r;
    assign dma.dma_wr_addr = wr_addr_r;
    assign dma.dma_rd_size = size_r;
    assign dma.dma_wr_size = size_r;
    assign dma.dma_wr_data = s2_r;
endmodule

// File: tb/tb_dma_pipe_ctrl.sv
// Randomised bench for dma_pipe_ctrl with a line-level reference model.
module tb_dma_pipe_ctrl;
    localparam int DW   = 128;
    localparam int AW   = 16;
    localparam int NL   = DW / 32;
    localparam int MAXL = 16;
    localparam logic [DW-1:0] WRAP_PAT = {32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFE};
    localparam logic [DW-1:0] WRAP_EXP = {32'h0000_0006, 32'h0000_0000, 32'h0000_0008, 32'hFFFF_FFFF};

    logic          clk = 1'b0;
    logic          rst, go, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [AW:0]   size;
    logic [31:0]   addend;

    dma_pipe_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dma ();

    dma_pipe_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .size(size), .addend(addend), .done(done), .dma(dma)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] src    [MAXL];
    logic [DW-1:0] expq   [MAXL];
    logic [DW-1:0] wr_log [MAXL];
    int            rd_cyc [MAXL];
    int            rd_cnt = 0, wr_cnt = 0, cur_size = 0, cyc = 0, run_cyc = 100;
    bit            active = 1'b0, lat_chk = 1'b0, bp_mode = 1'b0, rnd_mode = 1'b0, wr_done_sent = 1'b0;
    logic [AW-1:0] cur_rd = '0, cur_wr = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference rule: each 32-bit lane plus addend, wrapping within the lane
    function automatic logic [DW-1:0] model_line(input logic [DW-1:0] s, input logic [31:0] a);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*32 +: 32] = s[i*32 +: 32] + a;
        return r;
    endfunction

    function automatic logic [DW-1:0] gen_line(input int k, input int mode);
        logic [DW-1:0] l;
        logic [31:0]   kk;
        kk = k;
        l  = '0;
        for (int i = 0; i < NL; i++) l[i*32 +: 32] = (mode == 0) ? kk : $urandom;
        if (mode == 2 && k == 0) l = WRAP_PAT;
        return l;
    endfunction

    // Monitor/scoreboard: every mid-cycle sample, before the next edge
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("wr_en_while_full", {127'd0, dma.dma_wr_en & dma.dma_full}, '0);
            check("rd_en_while_empty", {127'd0, dma.dma_rd_en & dma.dma_empty}, '0);
            if (bp_mode) check("stall_quiet", {127'd0, dma.dma_full & (dma.dma_rd_en | dma.dma_wr_en)}, '0);
            if (active) begin
                check("rd_addr_hold", dma.dma_rd_addr, cur_rd);
                check("wr_addr_hold", dma.dma_wr_addr, cur_wr);
                check("rd_size_hold", dma.dma_rd_size, cur_size[AW:0]);
                check("wr_size_hold", dma.dma_wr_size, cur_size[AW:0]);
            end
            if (dma.dma_rd_en) begin
                check("rd_within_size", {127'd0, rd_cnt < cur_size}, 1);
                if (rd_cnt < MAXL) rd_cyc[rd_cnt] = cyc;
                rd_cnt++;
            end
            if (dma.dma_wr_en) begin
                check("wr_within_size", {127'd0, wr_cnt < cur_size}, 1);
                if (wr_cnt < cur_size) begin
                    check("wr_data", dma.dma_wr_data, expq[wr_cnt]);
                    wr_log[wr_cnt] = dma.dma_wr_data;
                    if (lat_chk) check("wr_latency", cyc - rd_cyc[wr_cnt], 2);
                end
                wr_cnt++;
            end
        end
    end

    // DMA peripheral model: FWFT read source, write sink, completion pulse
    initial begin
        dma.dma_rd_data = '0;
        dma.dma_empty   = 1'b1;
        dma.dma_full    = 1'b0;
        dma.dma_rd_done = 1'b0;
        dma.dma_wr_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dma.dma_rd_go) run_cyc = 0;
            else run_cyc++;
            dma.dma_rd_data = (rd_cnt < MAXL) ? src[rd_cnt] : '0;
            dma.dma_empty   = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b0;
            dma.dma_full    = bp_mode ? (run_cyc >= 3 && run_cyc <= 7)
                            : rnd_mode ? ($urandom_range(0, 99) < 25) : 1'b0;
            dma.dma_rd_done = active && (cur_size != 0) && (rd_cnt == cur_size);
            dma.dma_wr_done = 1'b0;
            if (active && !wr_done_sent && cur_size != 0 && wr_cnt == cur_size) begin
                dma.dma_wr_done = 1'b1;
                wr_done_sent    = 1'b1;
            end
        end
    end

    task automatic prep(input int n, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                        input logic [31:0] add, input int mode, input bit lat, input bit bp, input bit rnd);
        active   = 1'b0;
        lat_chk  = lat;
        bp_mode  = bp;
        rnd_mode = rnd;
        for (int k = 0; k < MAXL; k++) begin
            src[k]    = gen_line(k, mode);
            expq[k]   = model_line(src[k], add);
            wr_log[k] = '0;
        end
        rd_cnt = 0; wr_cnt = 0; cur_size = n; cur_rd = ra; cur_wr = wa; wr_done_sent = 1'b0;
        addend = add;
    endtask

    task automatic start(input int n);
        @(negedge clk);
        go = 1'b1; rd_addr = cur_rd; wr_addr = cur_wr; size = n[AW:0];
        @(posedge clk);
        #1;
        go = 1'b0; rd_addr = ~cur_rd; wr_addr = ~cur_wr; size = '1;
        active = 1'b1;
        check("rd_go_pulse", {127'd0, dma.dma_rd_go}, 1);
        check("wr_go_pulse", {127'd0, dma.dma_wr_go}, 1);
        check("done_cleared", {127'd0, done}, 0);
        @(posedge clk);
        #1;
        check("rd_go_single", {127'd0, dma.dma_rd_go}, 0);
        check("wr_go_single", {127'd0, dma.dma_wr_go}, 0);
    endtask

    task automatic finish_xfer(input int n);
        int budget;
        budget = 0;
        if (n == 0) begin
            check("size0_done", {127'd0, done}, 1);
        end else begin
            while (!done && budget < 400) begin
                @(posedge clk);
                #1;
                budget++;
            end
            check("done_timeout", {127'd0, done}, 1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("done_held", {127'd0, done}, 1);
        check("rd_total", rd_cnt, n);
        check("wr_total", wr_cnt, n);
        bp_mode = 1'b0; rnd_mode = 1'b0;
    endtask

    task automatic run_xfer(input int n, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                            input logic [31:0] add, input int mode, input bit lat, input bit bp, input bit rnd);
        prep(n, ra, wa, add, mode, lat, bp, rnd);
        start(n);
        finish_xfer(n);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"},   {127'd0, done}, 0);
        check({tag, "_rd_go"},  {127'd0, dma.dma_rd_go}, 0);
        check({tag, "_wr_go"},  {127'd0, dma.dma_wr_go}, 0);
        check({tag, "_rd_en"},  {127'd0, dma.dma_rd_en}, 0);
        check({tag, "_wr_en"},  {127'd0, dma.dma_wr_en}, 0);
        check({tag, "_rd_addr"}, dma.dma_rd_addr, '0);
        check({tag, "_wr_addr"}, dma.dma_wr_addr, '0);
        check({tag, "_size"},    dma.dma_rd_size, '0);
        check({tag, "_wr_data"}, dma.dma_wr_data, '0);
    endtask

    initial begin
        int b;
        rst = 1'b1; go = 1'b0; rd_addr = '0; wr_addr = '0; size = '0; addend = '0;
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle_no_rd_go", {127'd0, dma.dma_rd_go}, 0);
            check("idle_no_rd_en", {127'd0, dma.dma_rd_en}, 0);
        end

        // Basic transfer: lanes equal to line index, addend 1
        run_xfer(4, 16'h0100, 16'h0800, 32'd1, 0, 1'b1, 1'b0, 1'b0);
        check("basic_line0", wr_log[0], {4{32'd1}});
        check("basic_line3", wr_log[3], {4{32'd4}});

        // Lane wrap with untouched neighbours
        run_xfer(3, 16'h0200, 16'h0900, 32'd1, 2, 1'b1, 1'b0, 1'b0);
        check("wrap_line0", wr_log[0], WRAP_EXP);

        // Backpressure window on RUN cycles 3..7
        run_xfer(8, 16'h0300, 16'h0A00, 32'h10, 1, 1'b0, 1'b1, 1'b0);

        // Zero-length transfer, also a re-go from DONE with new addresses
        run_xfer(0, 16'h0400, 16'h0B00, 32'd5, 1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a 6-line transfer
        prep(6, 16'h0500, 16'h0C00, 32'd3, 1, 1'b0, 1'b0, 1'b0);
        start(6);
        b = 0;
        while (rd_cnt < 2 && b < 20) begin
            @(negedge clk);
            #2;
            b++;
        end
        check("mid_reads", rd_cnt, 2);
        rst = 1'b1;
        #1;
        active = 1'b0;
        check_quiet("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("post_rst_no_rd_go", {127'd0, dma.dma_rd_go}, 0);
            check("post_rst_no_rd_en", {127'd0, dma.dma_rd_en}, 0);
            check("post_rst_no_wr_en", {127'd0, dma.dma_wr_en}, 0);
        end
        run_xfer(2, 16'h0600, 16'h0D00, 32'd7, 1, 1'b1, 1'b0, 1'b0);

        // Randomised transfers with random empty/full
        for (int r = 0; r < 6; r++) begin
            run_xfer($urandom_range(1, 12), AW'($urandom), AW'($urandom), $urandom, 1, 1'b0, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dma_pipe_ctrl.md
DMA_PIPE_CTRL -- requirements
Module: dma_pipe_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning DMA data width in bits (cache line); multiple of 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 42, meaning DMA cache-line address width.
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port go  in  1  start pulse.
REQ-006 SHALL have port rd_addr  in  ADDR_WIDTH  source start address.
REQ-007 SHALL have port wr_addr  in  ADDR_WIDTH  destination start address.
REQ-008 SHALL have port size  in  ADDR_WIDTH+1  cache lines to transfer.
REQ-009 SHALL have port addend  in  32  per-lane constant.
REQ-010 SHALL have port done  out  1  transfer complete.
REQ-011 SHALL have ports dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en  out  1 each; dma_rd_addr, dma_wr_addr  out  ADDR_WIDTH; dma_rd_size, dma_wr_size  out  ADDR_WIDTH+1; dma_wr_data  out  DATA_WIDTH; dma_rd_data  in  DATA_WIDTH; dma_empty, dma_full, dma_rd_done, dma_wr_done  in  1. These match the DMA peripheral side.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE or DONE with go=1, register rd_addr, wr_addr and size; pulse dma_rd_go and dma_wr_go for exactly one cycle (the next cycle); clear done; enter RUN.
REQ-014 SHALL drive dma_rd_addr, dma_wr_addr, dma_rd_size and dma_wr_size from the registered values, held stable from the go pulse until the next go.
REQ-015 SHALL apply registered size=0 by entering DONE the cycle after go, with no dma_rd_en or dma_wr_en asserted.
REQ-016 SHALL implement a 2-stage datapath with valid bits v1 and v2, and advance = !(v2 && dma_full).
REQ-017 SHALL compute stage 2 data as each 32-bit lane of stage 1 plus addend, modulo 2^32 per lane, with no inter-lane carry.
REQ-018 SHALL assert dma_rd_en = (state==RUN) && !dma_empty && advance && (rd_count < size), and capture dma_rd_data into stage 1 in that same cycle.
REQ-019 SHALL assert dma_wr_en = v2 && !dma_full, with dma_wr_data driven from stage 2 registers.
REQ-020 SHALL, without stalls, present a line read at cycle t on dma_wr_data with dma_wr_en at cycle t+2, sustaining one line per cycle.
REQ-021 SHALL, when dma_full is held, freeze stage 1 and stage 2 contents and suppress dma_rd_en; no line is lost or duplicated.
REQ-022 SHALL keep rd_count (ADDR_WIDTH+1 bits) incrementing on dma_rd_en, and never exceed size.
REQ-023 SHALL move RUN to DONE on the first cycle dma_wr_done=1 while in RUN.
REQ-024 SHALL hold done=1 in DONE until the next accepted go; go in RUN SHALL be ignored.

Reset
REQ-025 SHALL, on rst (any cycle, including mid-RUN), clear to 0: state IDLE, done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, v1, v2, rd_count, and all address/size registers. Data registers SHALL also reset to 0.
REQ-026 SHALL, after rst deasserts, issue no DMA request until a new go.

Structure
REQ-027 SHALL place the FSM state enum and LANE_WIDTH=32 constant in shared package dma_pipe_pkg.
REQ-028 SHALL implement lane addition in one sub-module, lane_adder (combinational, DATA_WIDTH-parameterised), instantiated by dma_pipe_ctrl.

Verification
REQ-029 SHALL verify the basic transfer: size=4, addend=1, lines 0..3 with lanes = line index; dma_empty=0 and dma_full=0 throughout. Required: four dma_wr_en with lanes 1..4, in order; each line appears 2 cycles after its dma_rd_en; done after dma_wr_done.
REQ-030 SHALL verify wrap: lane value 0xFFFFFFFF with addend=1 produces output lane 0x00000000, with neighbouring lanes unaffected.
REQ-031 SHALL verify backpressure: size=8, dma_full=1 for cycles 3..7 of RUN. Required: no dma_rd_en or dma_wr_en while stalled; all 8 lines are written exactly once, in order.
REQ-032 SHALL verify size=0: done=1 the cycle after go; zero dma_rd_en or dma_wr_en.
REQ-033 SHALL verify reset mid-run: rst asserted after 2 of 6 lines are read. Required: all outputs are 0 immediately, asynchronously. A following go with size=2 then completes correctly.
REQ-034 SHALL verify re-go from DONE: go with new addresses. Required: a single-cycle dma_rd_go/dma_wr_go pulse; dma_rd_addr and dma_wr_addr update; done clears.
